// File: rtl/wd_pkg.sv
// Shared definitions for the multi-channel watchdog: fault-cause encoding,
// reset-request FSM states and a constant-friendly clog2.
package wd_pkg;

  // Value latched in cause_early when a channel faults
  localparam logic CAUSE_TIMEOUT = 1'b0;
  localparam logic CAUSE_EARLY   = 1'b1;

  // Reset-request pulse generator states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } rst_state_e;

  // Ceiling log2, usable in localparam expressions
  function automatic int clog2(input longint value);
    longint v;
    int     r;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wd_channel.sv
// One supervised heartbeat channel: idle counter, warning flag, sticky fault
// and the cause of that fault (timeout/forced vs early heartbeat).
module wd_channel
  import wd_pkg::*;
#(
  parameter int     CNT_W          = 32,
  parameter longint TIMEOUT_CYCLES = 1000000,
  parameter longint WARN_CYCLES    = 750000,
  parameter longint WINDOW_MIN     = 0
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  input  logic heartbeat,
  input  logic clear,
  input  logic force_reset,
  output logic warning,
  output logic triggered,
  output logic cause_early
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WARN_C    = CNT_W'(WARN_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             warning_reg;
  logic             triggered_reg;
  logic             cause_reg;
  logic             too_early;

  assign cnt_next = cnt_reg + ONE_C;

  // A heartbeat is only "early" when window mode is compiled in
  generate
    if (WINDOW_MIN > 0) begin : g_window
      localparam logic [CNT_W-1:0] WINDOW_C = CNT_W'(WINDOW_MIN);
      assign too_early = (cnt_reg < WINDOW_C);
    end else begin : g_no_window
      assign too_early = 1'b0;
    end
  endgenerate

  // Prioritised per-channel update: clear > disable > latched fault > force > heartbeat > count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg       <= '0;
      warning_reg   <= 1'b0;
      triggered_reg <= 1'b0;
      cause_reg     <= CAUSE_TIMEOUT;
    end else if (clear) begin
      cnt_reg       <= '0;
      warning_reg   <= 1'b0;
      triggered_reg <= 1'b0;
      cause_reg     <= CAUSE_TIMEOUT;
    end else if (!enable) begin
      cnt_reg     <= '0;
      warning_reg <= 1'b0;
    end else if (triggered_reg) begin
      // Fault is sticky: everything holds until clear
    end else if (force_reset) begin
      triggered_reg <= 1'b1;
      cause_reg     <= CAUSE_TIMEOUT;
    end else if (heartbeat && too_early) begin
      triggered_reg <= 1'b1;
      cause_reg     <= CAUSE_EARLY;
    end else if (heartbeat) begin
      cnt_reg     <= '0;
      warning_reg <= 1'b0;
    end else if (cnt_reg != TIMEOUT_C) begin
      // Counter stops at the timeout value so it can never wrap
      cnt_reg <= cnt_next;
      if (cnt_next >= WARN_C) begin
        warning_reg <= 1'b1;
      end
      if (cnt_next == TIMEOUT_C) begin
        triggered_reg <= 1'b1;
      end
    end
  end

  assign warning     = warning_reg;
  assign triggered   = triggered_reg;
  assign cause_early = cause_reg;

endmodule

// File: rtl/watchdog_multi.sv
// Multi-channel watchdog: NUM_CH channel slices, fault OR-reduction, new-fault
// edge detect and a stretched reset-request pulse for the board reset controller.
module watchdog_multi
  import wd_pkg::*;
#(
  parameter int     NUM_CH         = 4,
  parameter int     CNT_W          = 32,
  parameter longint TIMEOUT_CYCLES = 1000000,
  parameter longint WARN_CYCLES    = 750000,
  parameter longint WINDOW_MIN     = 0,
  parameter int     RST_PULSE      = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] heartbeat,
  input  logic [NUM_CH-1:0] clear,
  input  logic              force_reset,
  output logic [NUM_CH-1:0] warning,
  output logic [NUM_CH-1:0] triggered,
  output logic [NUM_CH-1:0] cause_early,
  output logic              any_triggered,
  output logic              reset_req
);

  localparam int              PCNT_W    = clog2(longint'(RST_PULSE) + 1);
  localparam logic [PCNT_W-1:0] PULSE_LEN = PCNT_W'(RST_PULSE);
  localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

  // Reject parameter sets that would make the thresholds meaningless
  generate
    if (WARN_CYCLES >= TIMEOUT_CYCLES) begin : g_bad_warn
      $error("watchdog_multi: WARN_CYCLES must be below TIMEOUT_CYCLES");
    end
    if ((CNT_W < 63) && (TIMEOUT_CYCLES >= (longint'(1) << CNT_W))) begin : g_bad_timeout
      $error("watchdog_multi: TIMEOUT_CYCLES does not fit in CNT_W bits");
    end
    if (RST_PULSE < 1) begin : g_bad_pulse
      $error("watchdog_multi: RST_PULSE must be at least 1");
    end
  endgenerate

  logic [NUM_CH-1:0] triggered_vec;
  logic [NUM_CH-1:0] trig_prev_reg;
  logic [NUM_CH-1:0] new_fault;
  logic              any_new_fault;
  rst_state_e        state_reg;
  logic [PCNT_W-1:0] pcnt_reg;
  logic              reset_req_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      wd_channel #(
        .CNT_W         (CNT_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .WARN_CYCLES   (WARN_CYCLES),
        .WINDOW_MIN    (WINDOW_MIN)
      ) u_ch (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable[gi]),
        .heartbeat  (heartbeat[gi]),
        .clear      (clear[gi]),
        .force_reset(force_reset),
        .warning    (warning[gi]),
        .triggered  (triggered_vec[gi]),
        .cause_early(cause_early[gi])
      );
    end
  endgenerate

  // A fault counts as new only on its 0->1 transition, so latched faults never retrigger
  assign new_fault     = triggered_vec & ~trig_prev_reg;
  assign any_new_fault = |new_fault;

  // Remember last cycle's fault vector for the edge detect
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trig_prev_reg <= '0;
    end else begin
      trig_prev_reg <= triggered_vec;
    end
  end

  // Reset-request pulse: a new fault (re)starts a RST_PULSE-cycle pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      pcnt_reg      <= '0;
      reset_req_reg <= 1'b0;
    end else if (any_new_fault) begin
      state_reg     <= ST_PULSE;
      pcnt_reg      <= PULSE_LEN;
      reset_req_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_PULSE: begin
          if (pcnt_reg <= PCNT_ONE) begin
            state_reg     <= ST_IDLE;
            pcnt_reg      <= '0;
            reset_req_reg <= 1'b0;
          end else begin
            pcnt_reg <= pcnt_reg - PCNT_ONE;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          pcnt_reg      <= '0;
          reset_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign triggered     = triggered_vec;
  assign any_triggered = |triggered_vec;
  assign reset_req     = reset_req_reg;

endmodule
